// File: rtl/seg7_scan_controller.sv
// Time-multiplexed 8-digit common-anode 7-segment scan controller with a
// double-buffered display word, per-digit enable/DP and leading-zero blanking.
module seg7_scan_controller #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int DIGIT_HZ     = 1000,
    parameter int NUM_DIGITS   = 8,
    parameter int BLANK_CYCLES = 64
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic [31:0] value_in,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  en_in,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic        lz_suppress,
    output logic        frame_tick,
    output logic [7:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP
);

    localparam int DWELL = CLK_HZ / DIGIT_HZ;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [2:0]       IDX_LAST  = 3'(NUM_DIGITS - 1);

    typedef enum logic {
        BLANK,
        SHOW
    } state_t;

    localparam state_t STATE_INIT = (BLANK_CYCLES > 0) ? BLANK : SHOW;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       idx_reg, idx_next;
    logic             slot_end, frame_end;

    logic [31:0] value_act_reg, value_pend_reg;
    logic [7:0]  dp_act_reg, dp_pend_reg;
    logic [7:0]  en_act_reg, en_pend_reg;
    logic        pend_full_reg;

    logic [7:0] an_reg, an_next;
    logic [6:0] seg_reg, seg_next;
    logic       dp_reg, dp_next;
    logic       frame_tick_reg;

    logic [7:0] upper_zero;
    logic [3:0] nibble;
    logic       visible;

    // upper_zero[i]: nibbles i..7 of the active word are all zero
    for (genvar gi = 0; gi < 8; gi++) begin : g_upper_zero
        assign upper_zero[gi] = (value_act_reg[31:4*gi] == '0);
    end

    assign nibble = value_act_reg[{idx_reg, 2'b00} +: 4];

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    always_comb begin
        slot_end  = (cnt_reg == CNT_LAST);
        frame_end = slot_end && (idx_reg == IDX_LAST);
        cnt_next  = slot_end ? '0 : cnt_reg + CNT_W'(1);
        idx_next  = idx_reg;
        if (frame_end) begin
            idx_next = '0;
        end else if (slot_end) begin
            idx_next = idx_reg + 3'd1;
        end
        // state tracks which part of the slot the counter is about to enter
        state_next = (cnt_next < BLANK_END) ? BLANK : SHOW;
    end

    always_comb begin
        an_next  = '1;
        seg_next = '1;
        dp_next  = 1'b1;
        visible  = en_act_reg[idx_reg]
                   && !(lz_suppress && (idx_reg != 3'd0) && upper_zero[idx_reg]);
        if (state_reg == SHOW) begin
            seg_next = hex_to_seg(nibble);
            dp_next  = ~dp_act_reg[idx_reg];
            if (visible) begin
                an_next[idx_reg] = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_reg      <= STATE_INIT;
            cnt_reg        <= '0;
            idx_reg        <= '0;
            an_reg         <= '1;
            seg_reg        <= '1;
            dp_reg         <= 1'b1;
            frame_tick_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            an_reg         <= an_next;
            seg_reg        <= seg_next;
            dp_reg         <= dp_next;
            frame_tick_reg <= frame_end;
        end
    end

    // Capture only while empty, commit only while full: the two never collide.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            value_act_reg  <= '0;
            dp_act_reg     <= '0;
            en_act_reg     <= '1;
            value_pend_reg <= '0;
            dp_pend_reg    <= '0;
            en_pend_reg    <= '0;
            pend_full_reg  <= 1'b0;
        end else if (load_valid && !pend_full_reg) begin
            value_pend_reg <= value_in;
            dp_pend_reg    <= dp_in;
            en_pend_reg    <= en_in;
            pend_full_reg  <= 1'b1;
        end else if (frame_end && pend_full_reg) begin
            value_act_reg  <= value_pend_reg;
            dp_act_reg     <= dp_pend_reg;
            en_act_reg     <= en_pend_reg;
            pend_full_reg  <= 1'b0;
        end
    end

    assign load_ready = ~pend_full_reg;
    assign frame_tick = frame_tick_reg;
    assign AN         = an_reg;
    assign SEG        = seg_reg;
    assign DP         = dp_reg;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Bench for seg7_scan_controller: directed steps plus random loads, compared
// every cycle against a time-index model of the scan and double buffer.
module tb_seg7_scan_controller;

    localparam int CLK_HZ       = 1000;
    localparam int DIGIT_HZ     = 100;
    localparam int NUM_DIGITS   = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int DWELL        = CLK_HZ / DIGIT_HZ;
    localparam int FRAME        = DWELL * NUM_DIGITS;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] value_in = '0;
    logic [7:0]  dp_in = '0;
    logic [7:0]  en_in = '0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic        lz_suppress = 1'b0;
    logic        frame_tick;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    always #5 clk = ~clk;

    seg7_scan_controller #(
        .CLK_HZ      (CLK_HZ),
        .DIGIT_HZ    (DIGIT_HZ),
        .NUM_DIGITS  (NUM_DIGITS),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .en_in      (en_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .lz_suppress(lz_suppress),
        .frame_tick (frame_tick),
        .AN         (an),
        .SEG        (seg),
        .DP         (dp)
    );

    typedef struct packed {
        logic [31:0] value;
        logic [7:0]  dp;
        logic [7:0]  en;
    } word_t;

    word_t      prod_q[$];
    word_t      act_m, pend_m, w1, w2;
    bit         full_m;
    int         t_m;
    int         commit_t[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] lit_mask;
    logic [6:0] seg_lut[16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, exp, t_m);
        end
    endtask

    task automatic model_reset();
        t_m    = 0;
        act_m  = '{value: 32'h0, dp: 8'h00, en: 8'hFF};
        pend_m = '0;
        full_m = 0;
    endtask

    // One clock: drive producer, clock, then compare against the model.
    task automatic step();
        int         pos, dig;
        bit         wrap, commit, accept, vis;
        logic [7:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        @(negedge clk);
        if (prod_q.size() > 0) begin
            load_valid = 1'b1;
            {value_in, dp_in, en_in} = prod_q[0];
        end else begin
            load_valid = 1'b0;
            value_in   = $urandom;
            dp_in      = 8'($urandom);
            en_in      = 8'($urandom);
        end
        @(posedge clk);
        #1;
        pos = t_m % DWELL;
        dig = (t_m / DWELL) % NUM_DIGITS;
        if (pos < BLANK_CYCLES) begin
            exp_an  = 8'hFF;
            exp_seg = 7'h7F;
            exp_dp  = 1'b1;
        end else begin
            exp_seg = seg_lut[(act_m.value >> (4 * dig)) & 32'hF];
            exp_dp  = !act_m.dp[dig];
            vis     = act_m.en[dig] &&
                      !(lz_suppress && dig > 0 && (act_m.value >> (4 * dig)) == 0);
            exp_an  = vis ? ~(8'd1 << dig) : 8'hFF;
        end
        wrap   = (t_m % FRAME) == FRAME - 1;
        commit = wrap && full_m;
        accept = !full_m && load_valid;
        if (commit) begin
            act_m  = pend_m;
            full_m = 0;
            commit_t.push_back(t_m);
        end
        if (accept) begin
            pend_m = prod_q.pop_front();
            full_m = 1;
        end
        t_m++;
        check("an", an, exp_an);
        check("seg", seg, exp_seg);
        check("dp", dp, exp_dp);
        check("ready", load_ready, !full_m);
        check("frame_tick", frame_tick, wrap);
        lit_mask |= ~an;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_commit();
        for (int n = 0; n < 4 * FRAME && !(prod_q.size() == 0 && !full_m); n++) step();
        check("commit_done", (prod_q.size() == 0 && !full_m), 1);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0d", t_m);
        $fatal(1, "watchdog");
    end

    initial begin
        seg_lut = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        model_reset();
        lit_mask = '0;

        // Reset values and the first frame of zeros
        repeat (3) @(posedge clk);
        #1;
        check("rst_an", an, 8'hFF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1'b1);
        check("rst_ready", load_ready, 1'b1);
        check("rst_tick", frame_tick, 1'b0);
        release_reset();
        run(3);
        check("d0_an", an, 8'hFE);
        check("d0_seg", seg, 7'b0000001);
        run(FRAME - 3);
        $display("step1 reset+first frame done t=%0d", t_m);

        // Mid-frame load, committed at the next boundary
        run(30);
        prod_q.push_back('{value: 32'h89ABCDEF, dp: 8'h01, en: 8'hFF});
        step();
        check("ready_low", load_ready, 1'b0);
        wait_commit();
        run(3);
        check("F_seg", seg, 7'b0111000);
        check("F_dp", dp, 1'b0);
        run(70);
        check("8_seg", seg, 7'b0000000);
        run(FRAME - 73);
        $display("step2 load 89ABCDEF committed t=%0d", t_m);

        // Back-to-back loads land in consecutive frames
        run(20);
        w1 = '{value: $urandom, dp: 8'($urandom), en: 8'hFF};
        w2 = '{value: $urandom, dp: 8'($urandom), en: 8'hFF};
        commit_t.delete();
        prod_q.push_back(w1);
        prod_q.push_back(w2);
        wait_commit();
        check("commits", commit_t.size(), 2);
        if (commit_t.size() == 2) check("commit_gap", commit_t[1] - commit_t[0], FRAME);
        run(3);
        check("w2_seg", seg, seg_lut[w2.value[3:0]]);
        $display("step3 back-to-back %h then %h t=%0d", w1.value, w2.value, t_m);

        // Leading-zero blanking
        lz_suppress = 1'b1;
        prod_q.push_back('{value: 32'h00000120, dp: 8'h00, en: 8'hFF});
        wait_commit();
        lit_mask = '0;
        run(FRAME);
        check("lz_120_lit", lit_mask, 8'h07);
        prod_q.push_back('{value: 32'h0, dp: 8'h00, en: 8'hFF});
        wait_commit();
        lit_mask = '0;
        run(FRAME);
        check("lz_0_lit", lit_mask, 8'h01);
        $display("step4 leading-zero suppression t=%0d", t_m);

        // Per-digit enable
        lz_suppress = 1'b0;
        prod_q.push_back('{value: $urandom, dp: 8'($urandom), en: 8'h0F});
        wait_commit();
        lit_mask = '0;
        run(3 * FRAME);
        check("en_0F_lit", lit_mask, 8'h0F);
        $display("step5 en=0F over 3 frames t=%0d", t_m);

        // Random loads with leading zeros and live lz toggling
        for (int i = 0; i < 12 * FRAME; i++) begin
            if ($urandom_range(0, 39) == 0 && prod_q.size() < 2)
                prod_q.push_back('{value: $urandom >> (4 * $urandom_range(0, 7)),
                                   dp: 8'($urandom), en: 8'($urandom)});
            if ($urandom_range(0, 99) == 0) lz_suppress = ~lz_suppress;
            step();
        end
        wait_commit();
        $display("step6 random phase done t=%0d", t_m);

        // Async reset during SHOW of digit 5 with a pending word
        lz_suppress = 1'b0;
        prod_q.push_back('{value: $urandom | 32'h8000_0000, dp: 8'h00, en: 8'hFF});
        wait_commit();
        prod_q.push_back('{value: 32'h76543210, dp: 8'hFF, en: 8'hFF});
        step();
        for (int n = 0; n < 2 * FRAME &&
             !(((t_m - 1) % DWELL) >= BLANK_CYCLES && ((t_m - 1) / DWELL) % NUM_DIGITS == 5); n++)
            step();
        check("d5_an", an, 8'hDF);
        check("d5_ready", load_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_an", an, 8'hFF);
        check("arst_seg", seg, 7'h7F);
        check("arst_dp", dp, 1'b1);
        check("arst_ready", load_ready, 1'b1);
        check("arst_tick", frame_tick, 1'b0);
        prod_q.delete();
        load_valid = 1'b0;
        repeat (2) @(posedge clk);
        release_reset();
        lit_mask = '0;
        run(2 * FRAME);
        check("post_rst_lit", lit_mask, 8'hFF);
        $display("step7 reset mid-show, pending discarded t=%0d", t_m);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
